// File: rtl/alu_muldiv.sv
// RV32M execution unit: pipelined multiplier and iterative restoring divider.
// Handles one operation at a time behind a valid/ready handshake on each side.
module alu_muldiv #(
    parameter int XLEN          = 32,
    parameter int MUL_LATENCY   = 2,
    parameter int DIV_EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [XLEN-1:0]  ZERO_X  = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  ONES_X  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  ONE_X   = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  MIN_X   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(MUL_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + ONE_X;
    endfunction

    state_t             state_r;
    logic [2:0]         op_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [XLEN-1:0]    out_r;
    logic [2*XLEN-1:0]  pipe_r [MUL_LATENCY];
    logic [XLEN-1:0]    quo_r;
    logic [XLEN-1:0]    rem_r;
    logic [XLEN-1:0]    div_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               spec_r;
    logic [XLEN-1:0]    spec_val_r;

    logic               accept_s;
    logic               div_signed_s;
    logic               in1_neg_s;
    logic               in2_neg_s;
    logic [XLEN-1:0]    abs1_s;
    logic [XLEN-1:0]    abs2_s;
    logic               div0_s;
    logic               ovf_s;
    logic               special_s;
    logic [XLEN-1:0]    spec_val_s;
    logic               mul_a_sgn_s;
    logic               mul_b_sgn_s;
    logic [2*XLEN-1:0]  mul_a_s;
    logic [2*XLEN-1:0]  mul_b_s;
    logic [2*XLEN-1:0]  prod_in_s;
    logic [XLEN:0]      trial_s;
    logic [XLEN-1:0]    quo_fix_s;
    logic [XLEN-1:0]    rem_fix_s;
    logic [2*XLEN-1:0]  pipe_last_s;
    logic [XLEN-1:0]    mul_res_s;

    // Request decode: operand conditioning, special-case detection and first product stage input.
    always_comb begin
        accept_s     = in_valid & (state_r == S_IDLE) & ~flush;
        div_signed_s = ~funct3[0];
        in1_neg_s    = div_signed_s & in1[XLEN-1];
        in2_neg_s    = div_signed_s & in2[XLEN-1];
        abs1_s       = in1_neg_s ? negate(in1) : in1;
        abs2_s       = in2_neg_s ? negate(in2) : in2;
        div0_s       = (in2 == ZERO_X);
        ovf_s        = div_signed_s & (in1 == MIN_X) & (in2 == ONES_X);
        special_s    = div0_s | ovf_s;
        if (div0_s) begin
            spec_val_s = funct3[1] ? in1 : ONES_X;
        end else if (ovf_s) begin
            spec_val_s = funct3[1] ? ZERO_X : MIN_X;
        end else begin
            spec_val_s = ZERO_X;
        end
        // Extending to 2*XLEN makes one unsigned multiply serve all four signedness mixes.
        mul_a_sgn_s  = (funct3[1:0] != 2'b11) & in1[XLEN-1];
        mul_b_sgn_s  = ~funct3[1] & in2[XLEN-1];
        mul_a_s      = {{XLEN{mul_a_sgn_s}}, in1};
        mul_b_s      = {{XLEN{mul_b_sgn_s}}, in2};
        prod_in_s    = mul_a_s * mul_b_s;
    end

    // Per-cycle datapath: restoring divide step, sign fix-up and multiply result select.
    always_comb begin
        trial_s     = {rem_r, quo_r[XLEN-1]} - {1'b0, div_r};
        quo_fix_s   = neg_q_r ? negate(quo_r) : quo_r;
        rem_fix_s   = neg_r_r ? negate(rem_r) : rem_r;
        pipe_last_s = pipe_r[MUL_LATENCY-1];
        if (op_r == 3'b000) begin
            mul_res_s = pipe_last_s[XLEN-1:0];
        end else begin
            mul_res_s = pipe_last_s[2*XLEN-1:XLEN];
        end
    end

    // Control FSM with the operand, product pipeline and divider registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            op_r       <= 3'b000;
            cnt_r      <= CNT_ZERO;
            out_r      <= ZERO_X;
            quo_r      <= ZERO_X;
            rem_r      <= ZERO_X;
            div_r      <= ZERO_X;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            spec_r     <= 1'b0;
            spec_val_r <= ZERO_X;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                pipe_r[i] <= {(2*XLEN){1'b0}};
            end
        end else if (flush && (state_r != S_IDLE)) begin
            state_r <= S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        op_r <= funct3;
                        if (!funct3[2]) begin
                            pipe_r[0] <= prod_in_s;
                            cnt_r     <= CNT_MUL;
                            state_r   <= S_MUL;
                        end else if (special_s && (DIV_EARLY_OUT != 0)) begin
                            out_r   <= spec_val_s;
                            state_r <= S_DONE;
                        end else begin
                            quo_r      <= abs1_s;
                            div_r      <= abs2_s;
                            rem_r      <= ZERO_X;
                            neg_q_r    <= in1_neg_s ^ in2_neg_s;
                            neg_r_r    <= in1_neg_s;
                            spec_r     <= special_s;
                            spec_val_r <= spec_val_s;
                            cnt_r      <= CNT_DIV;
                            state_r    <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_r == CNT_ZERO) begin
                        out_r   <= mul_res_s;
                        state_r <= S_DONE;
                    end else begin
                        for (int i = 1; i < MUL_LATENCY; i++) begin
                            pipe_r[i] <= pipe_r[i-1];
                        end
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                S_DIV: begin
                    // Non-negative trial keeps the subtraction and sets the quotient bit.
                    if (!trial_s[XLEN]) begin
                        rem_r <= trial_s[XLEN-1:0];
                        quo_r <= {quo_r[XLEN-2:0], 1'b1};
                    end else begin
                        rem_r <= {rem_r[XLEN-2:0], quo_r[XLEN-1]};
                        quo_r <= {quo_r[XLEN-2:0], 1'b0};
                    end
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= S_FIX;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                S_FIX: begin
                    if (spec_r) begin
                        out_r <= spec_val_r;
                    end else if (op_r[1]) begin
                        out_r <= rem_fix_s;
                    end else begin
                        out_r <= quo_fix_s;
                    end
                    state_r <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_DONE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == S_IDLE);
    assign busy      = (state_r != S_IDLE);
    assign out_valid = (state_r == S_DONE);
    assign out       = out_r;

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised and directed bench for alu_muldiv against an arithmetic reference model.
module tb_alu_muldiv;

    localparam int XLEN        = 32;
    localparam int MUL_LAT     = 2;
    localparam int DIV_LAT     = XLEN + 1;
    localparam int EARLY       = 1;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_muldiv #(.XLEN(XLEN), .MUL_LATENCY(MUL_LAT), .DIV_EARLY_OUT(EARLY)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .in1       (in1),
        .in2       (in2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        int          ia;
        int          ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        ia = a;
        ib = b;
        p  = 64'h0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 32'h0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f < 3'd4) return MUL_LAT;
        if (b == 32'h0) return (EARLY != 0) ? 1 : DIV_LAT;
        if (!f[0] && a == MIN_INT && b == 32'hFFFF_FFFF) return (EARLY != 0) ? 1 : DIV_LAT;
        return DIV_LAT;
    endfunction

    // Issue one op, scramble the inputs after accept, measure latency and consume the result.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        funct3 = f; in1 = a; in2 = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; funct3 = 3'($urandom); in1 = $urandom; in2 = $urandom;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        res = out;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h want 0", out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  f_t [16];
        logic [31:0] a_t [16];
        logic [31:0] b_t [16];
        logic [31:0] e_t [16];
        int          l_t [16];
        logic [31:0] res;
        int          lat;
        f_t = '{3'd1, 3'd3, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5, 3'd7,
                3'd4, 3'd7, 3'd4, 3'd6, 3'd5, 3'd6, 3'd5, 3'd7};
        a_t = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000,
                32'h1234_5678, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
        b_t = '{32'h2, 32'h2, 32'h2, 32'h2, 32'h2, 32'h2, 32'h2, 32'h2,
                32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        e_t = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001,
                32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'h0000_0000,
                32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h0000_0000, 32'h8000_0000};
        l_t = '{2, 2, 2, 2, 33, 33, 33, 33, 1, 1, 1, 1, 1, 1, 33, 33};
        for (int i = 0; i < 16; i++) begin
            run_op(f_t[i], a_t[i], b_t[i], res, lat);
            checks++;
            if (res !== e_t[i]) begin
                errors++;
                $display("FAIL directed_result[%0d] f3=%0d: got %h want %h", i, f_t[i], res, e_t[i]);
            end
            checks++;
            if (lat !== l_t[i]) begin
                errors++;
                $display("FAIL directed_latency[%0d] f3=%0d: got %0d want %0d", i, f_t[i], lat, l_t[i]);
            end
        end
    endtask

    task automatic test_random(input int n);
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          mode;
        for (int i = 0; i < n; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            mode = $urandom_range(0, 9);
            if (mode == 0) b = 32'h0;
            else if (mode == 1) begin a = MIN_INT; b = 32'hFFFF_FFFF; end
            else if (mode == 2) b = 32'($urandom_range(1, 17));
            else if (mode == 3) b = b | 32'h8000_0000;
            run_op(f, a, b, res, lat);
            checks++;
            if (res !== ref_result(f, a, b)) begin
                errors++;
                $display("FAIL random_result f3=%0d a=%h b=%h: got %h want %h", f, a, b, res, ref_result(f, a, b));
            end
            checks++;
            if (lat !== ref_latency(f, a, b)) begin
                errors++;
                $display("FAIL random_latency f3=%0d a=%h b=%h: got %0d want %0d", f, a, b, lat, ref_latency(f, a, b));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] expv;
        int          lat;
        expv = ref_result(3'd0, 32'd1234, 32'd5678);
        @(negedge clk);
        funct3 = 3'd0; in1 = 32'd1234; in2 = 32'd5678; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin lat = c; break; end
        end
        checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL bp_latency: got %0d want %0d", lat, MUL_LAT); end
        in_valid = 1'b1; funct3 = 3'd4; in1 = 32'd99; in2 = 32'd7;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out !== expv || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out=%h valid=%b in_ready=%b want out=%h valid=1 in_ready=0",
                         c, out, out_valid, in_ready, expv);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        checks++; if (out !== expv) begin errors++; $display("FAIL bp_out_kept: got %h want %h", out, expv); end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_ignored_req: busy got %b want 0", busy); end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int          lat;
        int          seen;
        @(negedge clk);
        funct3 = 3'd4; in1 = $urandom; in2 = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_result: out_valid seen %0d want 0", seen); end
        in_valid = 1'b1; flush = 1'b1; funct3 = 3'd0; in1 = 32'd2; in2 = 32'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_accept: busy got %b want 0", busy); end
        run_op(3'd0, 32'd3, 32'd5, res, lat);
        checks++; if (res !== 32'd15) begin errors++; $display("FAIL flush_then_mul: got %h want %h", res, 32'd15); end
        checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL flush_then_mul_lat: got %0d want %0d", lat, MUL_LAT); end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        @(negedge clk);
        funct3 = 3'd0; in1 = 32'd7; in2 = 32'd9; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        checks++; if (out !== 32'h0) begin errors++; $display("FAIL rst_mid_out: got %h want 0", out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_discard: out_valid seen %0d want 0", seen); end
        @(negedge clk);
        funct3 = 3'd5; in1 = 32'd100; in2 = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || out !== 32'h0) begin
            errors++;
            $display("FAIL rst_flush_both: busy=%b out=%h want busy=0 out=0", busy, out);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            f = 3'(i);
            a = $urandom;
            b = $urandom;
            run_op(f, a, b, res, lat);
            checks++;
            if (res !== ref_result(f, a, b)) begin
                errors++;
                $display("FAIL b2b_result f3=%0d a=%h b=%h: got %h want %h", f, a, b, res, ref_result(f, a, b));
            end
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; funct3 = 3'd0; in1 = 32'h0; in2 = 32'h0;
        flush = 1'b0; out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_mid_op();
        test_back_to_back();
        test_random(60);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised multi-cycle RV32M execution unit.
- Performs MUL/MULH/MULHSU/MULHU with a configurable pipeline depth, and DIV/DIVU/REM/REMU with an iterative restoring divider.
- Sits beside the single-cycle integer ALU in the execute stage. The core routes OP instructions with funct7 = FUNCT7_M here and stalls on the valid/ready handshake.
- One operation in flight at a time.

Parameters:
- XLEN, 32: operand and result width. Must be >= 8.
- MUL_LATENCY, 2: cycles from accept to out_valid for multiply ops. Range 1..4.
- DIV_EARLY_OUT, 1: when 1, divide-by-zero and signed-overflow cases complete in 1 cycle. When 0, they take the full divide latency.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request
- funct3  in  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- in1  in  XLEN  rs1 operand
- in2  in  XLEN  rs2 operand
- flush  in  1  abort current op (pipeline flush)
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- out  out  XLEN  result
- busy  out  1  op accepted and not yet consumed

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, out_valid=0, out=0, busy=0, in_ready=1 from the following cycle. Reset mid-operation discards the op; no result is produced.
- States: IDLE, MUL, DIV, FIX, DONE.
- in_ready = (state==IDLE). The request is accepted at edge E when in_valid & in_ready. Operands and funct3 are latched at E; later input changes are ignored.
- IDLE -> MUL when funct3<4.
- IDLE -> DIV when funct3>=4, except the special cases below.
- MUL:
  - Operands are sign-extended by one bit per op: MUL/MULH both signed; MULHSU in1 signed, in2 unsigned; MULHU both unsigned.
  - The 2*XLEN product is computed over MUL_LATENCY registered stages.
  - out = product[XLEN-1:0] for MUL, product[2*XLEN-1:XLEN] otherwise.
  - out_valid rises MUL_LATENCY cycles after E.
- DIV:
  - Latch |in1|, |in2| for signed ops, raw values for unsigned.
  - Record quotient sign = in1[XLEN-1]^in2[XLEN-1] and remainder sign = in1[XLEN-1] (signed ops only).
  - XLEN iterations, one quotient bit per cycle, counter XLEN-1 down to 0.
  - Then FIX: negate quotient/remainder per the recorded signs and select by op.
  - out_valid rises XLEN+1 cycles after E (33 for XLEN=32).
- Special cases (DIV_EARLY_OUT=1), out_valid 1 cycle after E:
  - Divisor 0: DIV/DIVU out = all ones; REM/REMU out = in1.
  - Signed overflow (in1 = MIN_INT, in2 = -1): DIV out = MIN_INT; REM out = 0.
  - With DIV_EARLY_OUT=0 the same values are produced at XLEN+1 cycles.
- DONE: out_valid=1 and out held stable until out_valid & out_ready at an edge, then -> IDLE.
  - in_ready rises the cycle after the handshake; no same-cycle accept.
  - out keeps its last value after out_valid drops.
- busy = (state != IDLE).
- flush=1 at an edge in any non-IDLE state -> IDLE, out_valid=0, result discarded. flush in IDLE with in_valid does not accept.
- Simultaneous rst and flush: rst wins (same end state).
- Arithmetic is mod 2^XLEN; no exceptions or flags.

Test Plan:
- MULH, in1=0xFFFFFFFF (-1), in2=0x00000002, MUL_LATENCY=2 -> out_valid 2 cycles after accept, out=0xFFFFFFFF. MULHU with the same operands -> out=0x00000001. MULHSU -> 0xFFFFFFFF. MUL -> 0xFFFFFFFE.
- DIV in1=-7 (0xFFFFFFF9), in2=2 -> out_valid at +33 cycles, out=0xFFFFFFFD (-3). REM -> 0xFFFFFFFF (-1). DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC. REMU -> 1.
- DIV by zero, in1=0x12345678, in2=0 -> out=0xFFFFFFFF at +1 cycle. REMU same operands -> 0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM -> 0.
- Backpressure: out_ready held 0 for 5 cycles after out_valid -> out stable, in_ready=0, a new in_valid is ignored. out_ready=1 -> next cycle in_ready=1.
- flush asserted 10 cycles into a DIV -> next cycle state IDLE, in_ready=1, out_valid never asserted. A subsequent MUL 3*5 -> out=15.
- rst asserted mid-MUL -> out_valid=0, out=0, busy=0 after the edge. Back-to-back ops after release complete correctly.
